// File: rtl/demux_1_4_tdm_if.sv
// Purpose: bus bundle between a 4-slot TDM word source and the 1:4 demultiplexer.
// Ports / signals:
//   in_valid, in_first, in_data : serialized word stream into the demux
//   d0..d3                      : lane outputs holding the last complete frame
//   out_valid                   : one-cycle pulse when d0..d3 take a new frame
//   sel                         : slot index the next non-first word will fill
//   frame_err                   : one-cycle pulse when an open frame is aborted
// Modports:
//   master : stream source / lane consumer side (drives in_*, observes outputs)
//   slave  : demultiplexer side (observes in_*, drives outputs)
interface demux_1_4_tdm_if #(
  parameter int unsigned W = 4
);

  logic         in_valid;
  logic         in_first;
  logic [W-1:0] in_data;

  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic         out_valid;
  logic [1:0]   sel;
  logic         frame_err;

  modport master (
    output in_valid,
    output in_first,
    output in_data,
    input  d0,
    input  d1,
    input  d2,
    input  d3,
    input  out_valid,
    input  sel,
    input  frame_err
  );

  modport slave (
    input  in_valid,
    input  in_first,
    input  in_data,
    output d0,
    output d1,
    output d2,
    output d3,
    output out_valid,
    output sel,
    output frame_err
  );

endinterface

// File: rtl/demux_1_4_tdm.sv
// Purpose: receive end of a 4-slot serialized word stream. Words are steered
// into shadow slots by a 2-bit slot counter; when the slot-3 word arrives the
// whole frame is published on d0..d3 in one edge with a one-cycle out_valid.
// An in_first inside an open frame aborts it (frame_err pulse) and restarts
// collection on the new word.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : demux_1_4_tdm_if.slave (in_valid/in_first/in_data in;
//         d0..d3/out_valid/sel/frame_err out, all registered)
module demux_1_4_tdm #(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             rst,
  demux_1_4_tdm_if.slave   bus
);

  localparam int unsigned N_SHADOW = 3;
  localparam int unsigned N_LANES  = 4;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  state_e                            state_q, state_d;
  logic [1:0]                        sel_q, sel_d;
  logic [N_SHADOW-1:0][W-1:0]        shadow_q, shadow_d;
  logic [N_LANES-1:0][W-1:0]         lane_q, lane_d;
  logic                              out_valid_q, out_valid_d;
  logic                              frame_err_q, frame_err_d;

  // State, slot counter, shadow slots and published lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= 2'd0;
      shadow_q    <= '0;
      lane_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      lane_q      <= lane_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    shadow_d    = shadow_q;
    lane_d      = lane_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Words without a frame marker are dropped silently while idle.
        if (bus.in_valid && bus.in_first) begin
          shadow_d[0] = bus.in_data;
          sel_d       = 2'd1;
          state_d     = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (bus.in_valid) begin
          if (bus.in_first) begin
            // Early marker: abandon the open frame and resync on this word.
            // Stale shadow[1..2] are overwritten before they can be published.
            frame_err_d = 1'b1;
            shadow_d[0] = bus.in_data;
            sel_d       = 2'd1;
          end else if (sel_q == 2'd3) begin
            // Slot-3 word goes straight to the lanes so all four update together.
            lane_d[0]   = shadow_q[0];
            lane_d[1]   = shadow_q[1];
            lane_d[2]   = shadow_q[2];
            lane_d[3]   = bus.in_data;
            out_valid_d = 1'b1;
            sel_d       = 2'd0;
            state_d     = ST_IDLE;
          end else begin
            case (sel_q)
              2'd1:    shadow_d[1] = bus.in_data;
              2'd2:    shadow_d[2] = bus.in_data;
              default: shadow_d[0] = bus.in_data;
            endcase
            sel_d = sel_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 2'd0;
      end
    endcase
  end

  assign bus.d0        = lane_q[0];
  assign bus.d1        = lane_q[1];
  assign bus.d2        = lane_q[2];
  assign bus.d3        = lane_q[3];
  assign bus.out_valid = out_valid_q;
  assign bus.sel       = sel_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: doc/demux_1_4_tdm.md
# demux_1_4_tdm

Time-division 1:4 demultiplexer: the receive end of a 4-slot serialized nibble stream produced by rotating a 4:1 mux over four lanes. Accepts one W-bit word per valid cycle, tagged with a frame-start marker, steers words into four lane slots by a 2-bit slot counter, and presents a complete, coherent frame on four registered outputs with a one-cycle valid pulse. Sits between a serial link source and four parallel lane consumers.

## Interface

- W, default 4, width of each data word and lane output.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_first carry a word this cycle.
- in_first  input  1  word is slot 0 of a new frame; ignored when in_valid=0.
- in_data  input  W  serialized word.
- d0, d1, d2, d3  output  W each  lane outputs, last complete frame (registered).
- out_valid  output  1  one-cycle pulse: d0..d3 just updated with a new frame.
- sel  output  2  slot index the next accepted non-first word will fill (registered).
- frame_err  output  1  one-cycle pulse: frame aborted by an early in_first.

## Operation

- States: IDLE (no frame open), COLLECT (frame open, slots 0..sel-1 held in shadow registers).
- Reset (async, any time): state=IDLE, sel=0, d0..d3=0, out_valid=0, frame_err=0, shadow registers=0. Partial frame in progress is discarded.
- IDLE:
  - in_valid=1, in_first=1: shadow[0]<=in_data, sel<=1, go COLLECT.
  - in_valid=1, in_first=0: word dropped, no state change, no error.
  - in_valid=0: hold.
- COLLECT:
  - in_valid=0: hold everything (gaps of any length allowed).
  - in_valid=1, in_first=0, sel<3: shadow[sel]<=in_data, sel<=sel+1.
  - in_valid=1, in_first=0, sel=3: {d3,d2,d1,d0}<={in_data,shadow[2],shadow[1],shadow[0]}, out_valid<=1, sel<=0, go IDLE.
  - in_valid=1, in_first=1: frame_err<=1, partial frame discarded, shadow[0]<=in_data, sel<=1, stay COLLECT (resynchronized on the new frame).
- d0..d3 change only on frame completion; all four update on the same edge (no partially updated frame is ever visible).
- out_valid and frame_err are deasserted in every cycle not listed above; never both high together.
- sel reads 0 in IDLE; in COLLECT equals count of words already captured (1..3).
- No backpressure: block accepts every valid word.

## Timing

- Latency: out_valid and new d0..d3 visible in the cycle after the edge capturing the slot-3 word (1 cycle).
- Minimum frame period 4 cycles; back-to-back frames with no idle cycle supported (IDLE accepts in_first on the cycle immediately after completion).
- frame_err asserted in the cycle after the edge sampling the offending in_first.
- rst deassertion: first word may be accepted on the first rising edge with rst low.
- All outputs are flop outputs; no combinational path from inputs to outputs.

## Test plan

- Frame a,b,c,d with in_first on a, 4 consecutive cycles -> after 4th edge d0=a,d1=b,d2=c,d3=d, out_valid high exactly 1 cycle, frame_err=0.
- Same frame with 2-cycle in_valid gaps between words -> identical d0..d3, single out_valid, sel steps 1,2,3,0 only on valid cycles.
- Words 5,6 (no in_first) in IDLE, then frame 1,2,3,4 -> 5,6 ignored, d0..d3=1,2,3,4, no frame_err.
- Frame 7,8 then in_first with 9, then A,B,C -> frame_err pulse 1 cycle after 9, d0..d3=9,A,B,C; 7,8 never appear.
- Back-to-back frames 1,2,3,4 and 5,6,7,8 over 8 cycles -> out_valid pulses after cycle 4 and 8, d0..d3 move 1,2,3,4 -> 5,6,7,8 atomically.
- Assert rst after 3 words of a frame (mid-cycle, async) -> d0..d3=0, sel=0, out_valid=0 immediately; following word without in_first dropped; next full frame delivered correctly.
